// File: rtl/sdram_traffic_pkg.sv
// Shared types and helpers for the SDRAM traffic checker: FSM state encoding,
// the per-lane test pattern, and the response-stall LFSR constants.
package sdram_traffic_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR   = 2'd1,
    S_RD   = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  // Galois form of x^16 + x^14 + x^13 + x^11 + 1, shifting right.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // One 16-bit lane of the address-derived pattern; wide buses repeat it per lane.
  function automatic logic [15:0] pat(input logic [15:0] addr_lo, input logic [15:0] seed_lane);
    return addr_lo ^ seed_lane;
  endfunction

endpackage

// File: rtl/sdram_traffic_lfsr.sv
// Free-running 16-bit LFSR whose bit 0 is used as pseudo-random response ready.
// Only instantiated when SDRAM_TRAFFIC_CHK_RSP_STALL_EN is defined.
module sdram_traffic_lfsr
  import sdram_traffic_pkg::*;
(
  input  logic clk,
  input  logic reset,
  output logic rsp_ready
);

  logic [15:0] value;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) value <= LFSR_SEED;
    else       value <= (value >> 1) ^ (value[0] ? LFSR_TAPS : 16'h0000);
  end

  assign rsp_ready = value[0];

endmodule

// File: rtl/sdram_traffic_checker.sv
// Self-checking SDRAM bus traffic engine: writes a pattern over an address window,
// reads it back with up to MAX_OUT reads in flight, and counts mismatches.
// Optional response backpressure: define SDRAM_TRAFFIC_CHK_RSP_STALL_EN.
//
// Handshake: a cmd or rsp transfer happens on a clock edge where valid && ready.
// Once cmd valid rises it stays high, with the payload frozen, until accepted.
module sdram_traffic_checker
  import sdram_traffic_pkg::*;
#(
  parameter int ADDR_W  = 24,
  parameter int DATA_W  = 16,
  parameter int CTX_W   = 8,
  parameter int MAX_OUT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [ADDR_W-1:0]     length,
  input  logic [DATA_W-1:0]     seed,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           error_count,
  output logic [ADDR_W-1:0]     first_err_addr,
  output logic                  io_bus_cmd_valid,
  input  logic                  io_bus_cmd_ready,
  output logic [ADDR_W-1:0]     io_bus_cmd_payload_address,
  output logic                  io_bus_cmd_payload_write,
  output logic [DATA_W-1:0]     io_bus_cmd_payload_data,
  output logic [DATA_W/8-1:0]   io_bus_cmd_payload_mask,
  output logic [CTX_W-1:0]      io_bus_cmd_payload_context,
  input  logic                  io_bus_rsp_valid,
  output logic                  io_bus_rsp_ready,
  input  logic [DATA_W-1:0]     io_bus_rsp_payload_data,
  input  logic [CTX_W-1:0]      io_bus_rsp_payload_context,
  output state_t                dbg_state
);

  localparam int OUT_W = $clog2(MAX_OUT) + 1;
  localparam int LANES = DATA_W / 16;
  localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);
  localparam logic [OUT_W-1:0]  OUT_MAX = OUT_W'(MAX_OUT);

  state_t state, state_nx;

  logic [ADDR_W-1:0] base_q, len_q, cmd_cnt, cmd_addr, rsp_addr;
  logic [DATA_W-1:0] seed_q;
  logic [CTX_W-1:0]  cmd_ctx, rsp_ctx;
  logic [OUT_W-1:0]  outstanding;
  logic              cmd_fire, rd_fire, rsp_chk, rsp_err, wr_last, start_run;

  function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a,
                                                input logic [DATA_W-1:0] s);
    logic [DATA_W-1:0] p;
    p = '0;
    for (int i = 0; i < LANES; i++) p[16*i +: 16] = pat(a[15:0], s[16*i +: 16]);
    return p;
  endfunction

`ifdef SDRAM_TRAFFIC_CHK_RSP_STALL_EN
  sdram_traffic_lfsr u_lfsr (
    .clk       (clk),
    .reset     (reset),
    .rsp_ready (io_bus_rsp_ready)
  );
`else
  assign io_bus_rsp_ready = 1'b1;
`endif

  assign dbg_state = state;

  always_comb begin
    start_run = (state == S_IDLE) && start;
    io_bus_cmd_valid = ((state == S_WR) && (cmd_cnt != len_q)) ||
                       ((state == S_RD) && (cmd_cnt != len_q) && (outstanding < OUT_MAX));
    io_bus_cmd_payload_address = cmd_addr;
    io_bus_cmd_payload_write   = (state == S_WR);
    io_bus_cmd_payload_data    = (state == S_WR) ? pattern(cmd_addr, seed_q) : '0;
    io_bus_cmd_payload_mask    = (state == S_WR) ? '1 : '0;
    io_bus_cmd_payload_context = (state == S_RD) ? cmd_ctx : '0;
    cmd_fire = io_bus_cmd_valid && io_bus_cmd_ready;
    rd_fire  = cmd_fire && (state == S_RD);
    wr_last  = cmd_fire && (state == S_WR) && (cmd_cnt + ONE_A == len_q);
    // Responses outside RD belong to no run and are dropped unchecked.
    rsp_chk  = io_bus_rsp_valid && io_bus_rsp_ready && (state == S_RD);
    rsp_err  = (io_bus_rsp_payload_data != pattern(rsp_addr, seed_q)) ||
               (io_bus_rsp_payload_context != rsp_ctx);
    busy = (state == S_WR) || (state == S_RD);
    done = (state == S_FIN);
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = (length == '0) ? S_FIN : S_WR;
      S_WR:    if (wr_last) state_nx = S_RD;
      S_RD:    if ((cmd_cnt == len_q) && (outstanding == '0)) state_nx = S_FIN;
      S_FIN:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_q         <= '0;
      len_q          <= '0;
      seed_q         <= '0;
      cmd_cnt        <= '0;
      cmd_addr       <= '0;
      rsp_addr       <= '0;
      cmd_ctx        <= '0;
      rsp_ctx        <= '0;
      outstanding    <= '0;
      error_count    <= '0;
      first_err_addr <= '0;
    end else if (start_run) begin
      base_q         <= base_addr;
      len_q          <= length;
      seed_q         <= seed;
      cmd_cnt        <= '0;
      cmd_addr       <= base_addr;
      rsp_addr       <= base_addr;
      cmd_ctx        <= '0;
      rsp_ctx        <= '0;
      outstanding    <= '0;
      error_count    <= '0;
      first_err_addr <= '0;
    end else begin
      // The same counters walk the window again for the read pass.
      if (wr_last) begin
        cmd_cnt  <= '0;
        cmd_addr <= base_q;
      end else if (cmd_fire) begin
        cmd_cnt  <= cmd_cnt + ONE_A;
        cmd_addr <= cmd_addr + ONE_A;
      end
      if (rd_fire) cmd_ctx <= cmd_ctx + CTX_W'(1);
      if (rsp_chk) begin
        rsp_addr <= rsp_addr + ONE_A;
        rsp_ctx  <= rsp_ctx + CTX_W'(1);
        if (rsp_err) begin
          if (error_count != 16'hFFFF) error_count <= error_count + 16'd1;
          // Count saturates rather than wraps, so zero means no error seen yet.
          if (error_count == 16'd0) first_err_addr <= rsp_addr;
        end
      end
      if (rd_fire && !rsp_chk)                        outstanding <= outstanding + OUT_W'(1);
      else if (!rd_fire && rsp_chk && outstanding != '0) outstanding <= outstanding - OUT_W'(1);
    end
  end

endmodule

// File: tb/tb_sdram_traffic_checker.sv
// Bench for sdram_traffic_checker: a memory/bus model on the cmd/rsp bus plus a
// window-level model of the expected write/read streams and error results.
module tb_sdram_traffic_checker;
  import sdram_traffic_pkg::*;

  localparam int AW = 24;
  localparam int DW = 16;
  localparam int CW = 8;
  localparam int MO = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0, length = '0;
  logic [DW-1:0] seed = '0;
  logic          busy, done;
  logic [15:0]   error_count;
  logic [AW-1:0] first_err_addr;
  logic          cmd_valid, cmd_ready = 1'b0, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_data;
  logic [DW/8-1:0] cmd_mask;
  logic [CW-1:0] cmd_ctx;
  logic          rsp_valid = 1'b0, rsp_ready;
  logic [DW-1:0] rsp_data = '0;
  logic [CW-1:0] rsp_ctx = '0;
  state_t        dbg_state;

  sdram_traffic_checker #(.ADDR_W(AW), .DATA_W(DW), .CTX_W(CW), .MAX_OUT(MO)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .length(length),
    .seed(seed), .busy(busy), .done(done), .error_count(error_count),
    .first_err_addr(first_err_addr),
    .io_bus_cmd_valid(cmd_valid), .io_bus_cmd_ready(cmd_ready),
    .io_bus_cmd_payload_address(cmd_addr), .io_bus_cmd_payload_write(cmd_write),
    .io_bus_cmd_payload_data(cmd_data), .io_bus_cmd_payload_mask(cmd_mask),
    .io_bus_cmd_payload_context(cmd_ctx),
    .io_bus_rsp_valid(rsp_valid), .io_bus_rsp_ready(rsp_ready),
    .io_bus_rsp_payload_data(rsp_data), .io_bus_rsp_payload_context(rsp_ctx),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  logic [AW+DW-1:0] exp_wr_q[$];   // {addr, data} of each expected write
  logic [AW+CW-1:0] exp_rd_q[$];   // {addr, ctx} of each expected read
  logic [AW-1:0]    wr_log[$];

  typedef struct {
    logic [DW-1:0] data;
    logic [CW-1:0] ctx;
    int            due;
  } rsp_t;
  rsp_t rsp_q[$];

  logic [DW-1:0] mem [int unsigned];
  int cyc = 0, ready_pct = 100, latency = 1, stall_after = -1, stall_left = 0;
  int wr_fires = 0, rd_fires = 0, rsp_fires = 0, cmd_valid_cycles = 0, done_pulses = 0;
  logic          corrupt_en = 1'b0;
  logic [AW-1:0] corrupt_addr = '0;
  logic [DW-1:0] word_at_10 = '0;
  logic          prev_stall = 1'b0;
  logic [AW+DW+CW:0] prev_payload = '0, cur_payload;

  // ---------------- bus model (drives inputs for the next rising edge) ----------------
  always @(negedge clk) begin
    cyc++;
    cur_payload = {cmd_addr, cmd_write, cmd_data, cmd_ctx};
    if (reset) begin
      cmd_ready  = 1'b0;
      rsp_valid  = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("cmd_valid_held", cmd_valid, 1'b1);
        check("cmd_payload_held", cur_payload, prev_payload);
      end
      if (done) done_pulses++;
      if (cmd_valid) cmd_valid_cycles++;
      if (stall_left > 0) begin
        cmd_ready = 1'b0;
        stall_left--;
      end else begin
        cmd_ready = ($urandom_range(99) < ready_pct);
      end
      if (cmd_valid && cmd_ready) begin
        if (cmd_write) begin
          wr_fires++;
          wr_log.push_back(cmd_addr);
          if (wr_fires == stall_after) stall_left = 5;
          if (exp_wr_q.size() > 0) check("write_cmd", {cmd_addr, cmd_data}, exp_wr_q.pop_front());
          check("write_mask", cmd_mask, 2'b11);
          check("write_ctx", cmd_ctx, 8'h00);
          mem[cmd_addr] = cmd_data;
          if (cmd_addr == 24'h000010) word_at_10 = cmd_data;
        end else begin
          rd_fires++;
          if (exp_rd_q.size() > 0) check("read_cmd", {cmd_addr, cmd_ctx}, exp_rd_q.pop_front());
          check("max_outstanding", (rd_fires - rsp_fires) <= MO, 1'b1);
          rsp_q.push_back('{data: mem[cmd_addr] ^ ((corrupt_en && cmd_addr == corrupt_addr) ? 16'h0100 : 16'h0000),
                            ctx: cmd_ctx, due: cyc + latency});
        end
      end
      prev_stall   = cmd_valid && !cmd_ready;
      prev_payload = cur_payload;
      if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
        rsp_valid = 1'b1;
        rsp_data  = rsp_q[0].data;
        rsp_ctx   = rsp_q[0].ctx;
        if (rsp_ready) begin
          void'(rsp_q.pop_front());
          rsp_fires++;
        end
      end else begin
        rsp_valid = 1'b0;
        rsp_data  = DW'($urandom);
        rsp_ctx   = CW'($urandom);
      end
    end
  end

  // ---------------- driver tasks ----------------
  int            exp_err;
  logic [AW-1:0] exp_first;
  logic [AW-1:0] run_len;

  task automatic prep_run(input logic [AW-1:0] b, input logic [AW-1:0] l, input logic [DW-1:0] s,
                          input int rpct, input int lat, input int stall_at,
                          input logic cen, input logic [AW-1:0] caddr);
    logic [AW-1:0] a;
    exp_wr_q.delete();
    exp_rd_q.delete();
    wr_log.delete();
    exp_err = 0;
    exp_first = '0;
    for (int i = 0; i < int'(l); i++) begin
      a = b + AW'(i);
      exp_wr_q.push_back({a, a[15:0] ^ s});
      exp_rd_q.push_back({a, CW'(i)});
      if (cen && a == caddr) begin
        if (exp_err == 0) exp_first = a;
        exp_err++;
      end
    end
    run_len = l;
    ready_pct = rpct; latency = lat; stall_after = stall_at; stall_left = 0;
    corrupt_en = cen; corrupt_addr = caddr;
    wr_fires = 0; rd_fires = 0; rsp_fires = 0; cmd_valid_cycles = 0; done_pulses = 0;
    @(negedge clk);
    start = 1'b1; base_addr = b; length = l; seed = s;
    @(negedge clk);
    start = 1'b0;
    base_addr = AW'($urandom); length = AW'($urandom); seed = DW'($urandom);
  endtask

  task automatic finish_run(input string tag);
    int n;
    if (run_len == '0) check({tag, "_done_next_cycle"}, done, 1'b1);
    else               check({tag, "_busy"}, busy, 1'b1);
    n = 0;
    while (!done && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_seen"}, done, 1'b1);
    check({tag, "_busy_at_done"}, busy, 1'b0);
    check({tag, "_error_count"}, error_count, 16'(exp_err));
    check({tag, "_first_err_addr"}, first_err_addr, exp_first);
    check({tag, "_writes"}, wr_fires, run_len);
    check({tag, "_reads"}, rd_fires, run_len);
    check({tag, "_rsps"}, rsp_fires, run_len);
    check({tag, "_wr_left"}, exp_wr_q.size(), 0);
    check({tag, "_rd_left"}, exp_rd_q.size(), 0);
    @(negedge clk);
    check({tag, "_done_once"}, done_pulses, 1);
    check({tag, "_idle"}, dbg_state, S_IDLE);
  endtask

  task automatic run(input logic [AW-1:0] b, input logic [AW-1:0] l, input logic [DW-1:0] s,
                     input int rpct, input int lat, input int stall_at,
                     input logic cen, input logic [AW-1:0] caddr, input string tag);
    prep_run(b, l, s, rpct, lat, stall_at, cen, caddr);
    finish_run(tag);
  endtask

  // ---------------- stimulus ----------------
  logic [AW-1:0] wrap_exp [4];
  initial begin
    logic [AW-1:0] rb, rl;
    int n;
    wrap_exp = '{24'hFFFFFE, 24'hFFFFFF, 24'h000000, 24'h000001};
    #2 reset = 1'b1;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_error_count", error_count, 16'h0000);
    check("rst_first_err_addr", first_err_addr, 24'h000000);
    check("rst_cmd_valid", cmd_valid, 1'b0);
    check("rst_cmd_addr", cmd_addr, 24'h000000);
    check("rst_rsp_ready", rsp_ready, 1'b1);
    check("rst_state", dbg_state, S_IDLE);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    run(24'h000010, 24'd8, 16'h5A5A, 100, 1, -1, 1'b0, '0, "basic");
    check("basic_word_at_10", word_at_10, 16'h5A4A);

    run(24'h000010, 24'd8, 16'h5A5A, 100, 3, -1, 1'b1, 24'h000013, "corrupt");
    check("corrupt_count_literal", error_count, 16'd1);
    check("corrupt_addr_literal", first_err_addr, 24'h000013);

    run(24'h000100, 24'd12, 16'h1234, 100, 2, 3, 1'b0, '0, "wr_stall");
    run(24'h000200, 24'd16, 16'hBEEF, 100, 20, -1, 1'b0, '0, "lat20");

    run(24'hFFFFFE, 24'd4, 16'h0F0F, 80, 2, -1, 1'b0, '0, "wrap");
    check("wrap_count", wr_log.size(), 4);
    for (int i = 0; i < 4 && i < wr_log.size(); i++) check("wrap_addr", wr_log[i], wrap_exp[i]);

    run(24'h000040, 24'd0, 16'h1111, 100, 1, -1, 1'b0, '0, "len0");
    check("len0_no_cmd_valid", cmd_valid_cycles, 0);

    // Abandon a run mid-read; the bus model keeps its in-flight responses.
    prep_run(24'h000300, 24'd16, 16'h2222, 100, 10, -1, 1'b0, '0);
    n = 0;
    while (!(dbg_state == S_RD && rd_fires >= 2) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("abort_reached_rd", dbg_state, S_RD);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_cmd_valid", cmd_valid, 1'b0);
    check("abort_state", dbg_state, S_IDLE);
    check("abort_rsp_ready", rsp_ready, 1'b1);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    n = 0;
    while (rsp_q.size() > 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("abort_late_drained", rsp_q.size(), 0);
    @(negedge clk);
    check("abort_late_discarded", error_count, 16'h0000);
    run(24'h000300, 24'd16, 16'h2222, 70, 5, -1, 1'b0, '0, "after_abort");

    for (int k = 0; k < 6; k++) begin
      rb = AW'($urandom);
      rl = AW'($urandom_range(1, 40));
      run(rb, rl, DW'($urandom), $urandom_range(30, 100), $urandom_range(1, 20), -1,
          ($urandom_range(1) == 1), rb + AW'($urandom_range(0, int'(rl) - 1)), "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, got no end of test, expected one");
    $fatal(1, "watchdog");
  end

endmodule
